// File: rtl/ex_muldiv_ctrl_pkg.sv
// rtl/ex_muldiv_ctrl_pkg.sv - shared constants and state encoding for the RV32M sequencer
package ex_muldiv_ctrl_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - one combinational shift-add multiply or restoring divide step
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   op_a_i,
    input  logic [WIDTH-1:0]   op_b_i,
    input  logic               is_div_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0]   op_a_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // Multiply: acc is the 64-bit product, op_a the multiplier shifting right.
    // Divide: acc low word is the partial remainder, op_a collects quotient bits.
    always_comb begin
        sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, op_b_i & {WIDTH{op_a_i[0]}}};
        rem_sh = {acc_i[WIDTH-1:0], op_a_i[WIDTH-1]};
        diff   = rem_sh - {1'b0, op_b_i};
        if (is_div_i) begin
            if (!diff[WIDTH]) begin
                acc_o  = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
                op_a_o = {op_a_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o  = {{WIDTH{1'b0}}, rem_sh[WIDTH-1:0]};
                op_a_o = {op_a_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o  = {sum, acc_i[WIDTH-1:1]};
            op_a_o = {1'b0, op_a_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// rtl/ex_muldiv_ctrl.sv - EX-stage multi-cycle RV32M multiply/divide sequencer with pipeline stall
module ex_muldiv_ctrl
    import ex_muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic             kill,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         f3_q, f3_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   res_q, res_d;

    logic [2*WIDTH-1:0] iter_acc;
    logic [WIDTH-1:0]   iter_a;
    logic               sgn_a, sgn_b;
    logic               div_zero, div_ovf;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .acc_i    (acc_q),
        .op_a_i   (a_q),
        .op_b_i   (b_q),
        .is_div_i (is_div_op(f3_q)),
        .acc_o    (iter_acc),
        .op_a_o   (iter_a)
    );

    // MUL's low word is sign-agnostic, so it runs as unsigned.
    assign sgn_a = rs1[WIDTH-1] & (funct3 == F3_MULH || funct3 == F3_MULHSU ||
                                   funct3 == F3_DIV  || funct3 == F3_REM);
    assign sgn_b = rs2[WIDTH-1] & (funct3 == F3_MULH || funct3 == F3_DIV || funct3 == F3_REM);

    assign div_zero = is_div_op(funct3) && (rs2 == '0);
    assign div_ovf  = (funct3 == F3_DIV || funct3 == F3_REM) && (rs1 == MIN_NEG) && (rs2 == ALL_ONE);

    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = neg_q ? -a_q : a_q;
    assign rem_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        neg_d   = neg_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !kill) begin
                    f3_d  = funct3;
                    a_d   = sgn_a ? -rs1 : rs1;
                    b_d   = sgn_b ? -rs2 : rs2;
                    acc_d = '0;
                    cnt_d = '0;
                    neg_d = (funct3 == F3_REM || funct3 == F3_REMU) ? sgn_a : (sgn_a ^ sgn_b);
                    if (div_zero) begin
                        res_d   = funct3[1] ? rs1 : ALL_ONE;
                        state_d = ST_DONE;
                    end else if (div_ovf) begin
                        res_d   = funct3[1] ? '0 : MIN_NEG;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (kill) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = iter_acc;
                    a_d   = iter_a;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH-1)) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                if (kill) begin
                    state_d = ST_IDLE;
                end else begin
                    case (f3_q)
                        F3_MUL:                   res_d = prod_fix[WIDTH-1:0];
                        F3_MULH, F3_MULHSU,
                        F3_MULHU:                 res_d = prod_fix[2*WIDTH-1:WIDTH];
                        F3_DIV, F3_DIVU:          res_d = quo_fix;
                        default:                  res_d = rem_fix;
                    endcase
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
        end
    end

    assign busy         = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign stall        = ((state_q == ST_IDLE) && start && !kill) || busy;
    assign result       = res_q;
    assign result_valid = (state_q == ST_DONE);

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// tb/tb_ex_muldiv_ctrl.sv - directed self-checking bench for ex_muldiv_ctrl
module tb_ex_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2;
    logic        kill;
    logic        stall, busy, result_valid;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_valid_cyc = 0;

    ex_muldiv_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .funct3       (funct3),
        .rs1          (rs1),
        .rs2          (rs2),
        .kill         (kill),
        .stall        (stall),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called #1 into an IDLE cycle; returns #1 into the IDLE cycle after DONE.
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int k;
        int stall_low;
        logic seen;
        start = 1'b1; funct3 = f3; rs1 = a; rs2 = b;
        #1;
        check({tag, "_stall_T"}, 64'(stall), 64'd1);
        @(posedge clk); #1;
        start = 1'b0; rs1 = 32'hDEAD_BEEF; rs2 = 32'h1234_5678;
        k = 1; seen = 1'b0; stall_low = 0;
        while (!seen && k < 60) begin
            if (result_valid) begin
                seen = 1'b1;
            end else begin
                if (!stall) stall_low++;
                @(posedge clk); #1;
                k++;
            end
        end
        check({tag, "_lat"}, 64'(seen ? k : -1), 64'(exp_lat));
        check({tag, "_res"}, 64'(result), 64'(exp_res));
        check({tag, "_stall_done"}, 64'(stall), 64'd0);
        check({tag, "_stall_gap"}, 64'(stall_low), 64'd0);
        last_valid_cyc = cyc;
        @(posedge clk); #1;
        check({tag, "_pulse"}, 64'(result_valid), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int first_valid;
        int rv_seen;
        rst = 1'b1; start = 1'b0; funct3 = 3'b000; rs1 = '0; rs2 = '0; kill = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(result_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);

        do_op("mul_7_m3",   3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        do_op("mulhu_max",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        do_op("mulh_min",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        do_op("mulhsu",     3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        do_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
        do_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
        do_op("divu_100_7", 3'b101, 32'd100,       32'd7,         32'd14,        34);
        do_op("remu_100_7", 3'b111, 32'd100,       32'd7,         32'd2,         34);
        do_op("div_5_0",    3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        do_op("rem_5_0",    3'b110, 32'd5,         32'd0,         32'd5,         1);
        do_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        do_op("b2b_mul",    3'b000, 32'd6,         32'd9,         32'd54,        34);
        first_valid = last_valid_cyc;
        do_op("b2b_divu",   3'b101, 32'd1000,      32'd33,        32'd30,        34);
        check("b2b_spacing", 64'(last_valid_cyc - first_valid), 64'd35);

        start = 1'b1; funct3 = 3'b100; rs1 = 32'd100; rs2 = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        rv_seen = 0;
        for (int k = 1; k < 10; k++) begin
            if (result_valid) rv_seen++;
            @(posedge clk); #1;
        end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        if (result_valid) rv_seen++;
        check("kill_busy", 64'(busy), 64'd0);
        check("kill_stall", 64'(stall), 64'd0);
        check("kill_no_valid", 64'(rv_seen), 64'd0);
        @(posedge clk); #1;
        do_op("after_kill_mul", 3'b000, 32'd3, 32'd4, 32'd12, 34);

        start = 1'b1; funct3 = 3'b000; rs1 = 32'd11; rs2 = 32'd13;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst_stall", 64'(stall), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_valid", 64'(result_valid), 64'd0);
        check("mrst_result", 64'(result), 64'd0);

        start = 1'b1; kill = 1'b1; funct3 = 3'b001; rs1 = 32'd2; rs2 = 32'd3;
        #1;
        check("skill_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        check("skill_busy", 64'(busy), 64'd0);
        check("skill_valid", 64'(result_valid), 64'd0);

        do_op("final_remu", 3'b111, 32'd1000, 32'd33, 32'd10, 34);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_ctrl.md
Name: ex_muldiv_ctrl

Overview:
- Multi-cycle sequencer for RV32M multiply/divide in the EX stage, alongside the single-cycle ALU.
- When decode flags an M-extension op, it captures operands and runs a 32-iteration shift-add multiply or restoring divide.
- It holds the pipeline stall high until the result is ready, then presents the result for one cycle so the EX/MEM register can latch it.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported (iteration count = WIDTH).
- CNT_W, 5, iteration counter width; must equal clog2(WIDTH).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  M-op present in EX this cycle (decode MulDiv & valid)
- funct3  in  3  inst[14:12]: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  in  WIDTH  forwarded operand A (dividend / multiplicand)
- rs2  in  WIDTH  forwarded operand B (divisor / multiplier)
- kill  in  1  flush of the EX instruction (branch taken / trap)
- stall  out  1  freeze PC, IF/ID, ID/EX
- busy  out  1  state is neither IDLE nor DONE
- result  out  WIDTH  final value; valid only while result_valid=1
- result_valid  out  1  one-cycle pulse in DONE

Behaviour:
- Reset (rst=1 at edge): state=IDLE, counter=0, all internal registers 0, result=0, result_valid=0, busy=0. Reset overrides every other input.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - Accepts when start=1 & kill=0 (accept cycle T). Latches funct3 and operand magnitudes; signedness comes from funct3.
  - Fast path: DIV/DIVU/REM/REMU with rs2=0, or DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF, go to DONE.
  - Otherwise go to CALC with counter=0.
- CALC: one iteration per cycle, counter++. After the counter=31 iteration, go to FIX.
- FIX: apply sign correction (negate product/quotient/remainder as required), select high or low word, register result. Next state DONE.
- DONE: result_valid=1, stall=0, start ignored. Next state IDLE.
- Latency: normal op gives result_valid at T+34 (CALC T+1..T+32, FIX T+33). Fast path gives result_valid at T+1.
- stall = (state==IDLE & start & ~kill) | busy. It is combinational in IDLE so the requesting instruction never leaves EX early.
- Back-to-back M-ops: second instruction arrives in EX the cycle after DONE and is accepted from IDLE. No bubble beyond that.
- Arithmetic:
  - Signed operands are converted to magnitude at accept.
  - The product is a 64-bit accumulator. MULHSU treats only rs1 as signed.
  - Remainder sign follows dividend; quotient sign = sign(rs1) XOR sign(rs2).
- Divide by zero: quotient = 0xFFFFFFFF, remainder = rs1 (unchanged, signed or unsigned).
- Signed overflow (0x80000000 / -1): quotient = 0x80000000, remainder = 0.
- kill:
  - In any state other than IDLE: next state IDLE, no result_valid, registers may hold stale data.
  - In IDLE with start=1: no accept, stall=0.
  - In DONE: result_valid still asserted this cycle (instruction already retiring).
- Reset mid-operation: IDLE on the next edge, no result_valid.
- result holds its last value between ops and is only meaningful with result_valid.

Decomposition:
- Shared package: funct3 op constants (MUL..REMU), state encoding (IDLE=0, CALC=1, FIX=2, DONE=3), WIDTH default.
- One natural sub-module: muldiv_iter. It is a combinational single step taking {acc, op_a, op_b, is_div} to the next {acc, op_a}; shift-add for multiply, compare-subtract-shift for divide.
- FSM, counter, sign fix-up, fast-path detection and stall logic stay in ex_muldiv_ctrl.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), start at T -> stall 1 for T..T+33, result_valid at T+34 only, result=0xFFFFFFEB. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULH 0x80000000*0x80000000 -> 0x40000000.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. Each at T+34.
- DIV 5/0 -> result_valid at T+1, result=0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1. REM same operands -> 0.
- Back-to-back MUL then DIVU: second accepted the cycle after first DONE. Exactly two result_valid pulses, 35 cycles apart. stall low only in each DONE cycle.
- kill at T+10 of a DIV -> IDLE at T+11, stall 0, no result_valid. New MUL 3*4 started at T+12 -> 12 at T+46.
- rst at T+20 of a MUL -> all outputs 0 next cycle, no result_valid. start with kill=1 in IDLE -> stall=0, state stays IDLE.
